// File: rtl/rst_sequencer_pkg.sv
// Shared state encoding and default release timing for the reset sequencer
// and anything that needs to agree with it on release times.
package rst_sequencer_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_HOLD_CYCLES = 20;
  localparam int DEF_STAGE_GAP   = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/rst_seq_counter.sv
// Clearable up-counter with a programmable terminal value; shared by the
// hold phase and the inter-channel gap phase.
module rst_seq_counter
  import rst_sequencer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clear has priority over counting
  always_comb begin
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/rst_sequencer.sv
// Reset-release controller: holds all channels in reset, then releases them
// in order with a fixed gap; supports a req/ack software re-reset.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_req,
  output logic              soft_ack,
  input  logic [NUM_CH-1:0] hold_mask,
  output logic [NUM_CH-1:0] ch_rst_out,
  output logic              done,
  output logic              busy
);

  localparam int IDX_W = $clog2(NUM_CH + 1);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              soft_ack_q, soft_ack_d;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_term;

  rst_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term),
    .tc   (cnt_tc)
  );

  // next-state and next-output logic; the counter is cleared on every state change
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ch_rst_d   = ch_rst_q;
    done_d     = done_q;
    busy_d     = busy_q;
    soft_ack_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_term   = CNT_W'(HOLD_CYCLES - 1);
    case (state_q)
      S_HOLD: begin
        cnt_term = CNT_W'(HOLD_CYCLES - 1);
        if (cnt_tc) begin
          cnt_clr     = 1'b1;
          ch_rst_d[0] = hold_mask[0];
          idx_d       = IDX_W'(1);
          if (NUM_CH == 1) begin
            state_d = S_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RELEASE: begin
        cnt_term = CNT_W'(STAGE_GAP - 1);
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          // a masked channel still consumes its slot but stays asserted
          for (int i = 0; i < NUM_CH; i++) begin
            ch_rst_d[i] = ((IDX_W'(i) == idx_q) && !hold_mask[i]) ? 1'b0 : ch_rst_q[i];
          end
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RUN: begin
        cnt_clr = 1'b1;
        if (soft_req) begin
          soft_ack_d = 1'b1;
          state_d    = S_HOLD;
          idx_d      = '0;
          ch_rst_d   = '1;
          done_d     = 1'b0;
          busy_d     = 1'b1;
        end else begin
          ch_rst_d = hold_mask;
        end
      end
      default: begin
        cnt_clr  = 1'b1;
        state_d  = S_HOLD;
        idx_d    = '0;
        ch_rst_d = '1;
        done_d   = 1'b0;
        busy_d   = 1'b1;
      end
    endcase
  end

  // state and registered outputs; rst forces a fresh hold from any state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_HOLD;
      idx_q      <= '0;
      ch_rst_q   <= '1;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      soft_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ch_rst_q   <= ch_rst_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      soft_ack_q <= soft_ack_d;
    end
  end

  assign ch_rst_out = ch_rst_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign soft_ack   = soft_ack_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Synthesizable, parametrised reset-release controller. It replaces the single fixed "hold reset, then drop it" stimulus used around Top.
- It holds NUM_CH downstream active-high reset lines asserted for a programmable count after system reset.
- It then releases the lines one by one, channel 0 first, with a fixed cycle gap between channels.
- It supports a software-requested re-reset using a req/ack handshake and a per-channel hold mask.
- It sits between the board or bench reset and the core, cache and peripheral reset inputs.

Parameters:
NUM_CH, 4, number of reset channels (>=1)
HOLD_CYCLES, 20, cycles all channels stay asserted after a reset source is released (>=1)
STAGE_GAP, 4, cycles between release of channel i and channel i+1 (>=1)
CNT_W, 8, counter width; must hold max(HOLD_CYCLES, STAGE_GAP)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
soft_req  in  1  software re-reset request; level, held until soft_ack
soft_ack  out  1  one-cycle pulse when soft_req is accepted
hold_mask  in  NUM_CH  1 = keep channel in reset regardless of sequence
ch_rst_out  out  NUM_CH  active-high reset to downstream blocks
done  out  1  1 when sequence complete (state RUN)
busy  out  1  1 while in HOLD or RELEASE

Behaviour:
- All outputs are registered. rst is sampled only on rising clk.
- rst=0 at an edge forces: state=HOLD, cnt=0, idx=0, ch_rst_out=all ones, done=0, busy=1, soft_ack=0. This applies in any state, mid-sequence included.
- E0 denotes the first edge at which rst is sampled 1.
- States:
  - HOLD: cnt increments each edge. When cnt==HOLD_CYCLES-1: go to RELEASE, clear ch_rst_out[0] (unless masked), idx=1, cnt=0. ch0 therefore drops after edge E(HOLD_CYCLES-1) and is observed low from cycle HOLD_CYCLES.
  - RELEASE: cnt counts to STAGE_GAP-1, then clears ch_rst_out[idx] (unless masked), idx++, cnt=0. When the last channel is cleared, go to RUN on the same edge; done=1 and busy=0 on that edge.
  - RUN: done=1. Each bit follows ch_rst_out[i] = hold_mask[i] every cycle. Setting a mask bit re-asserts that channel next cycle; clearing it releases it next cycle.
- Masking during HOLD/RELEASE:
  - A masked channel stays asserted.
  - Its release slot is still consumed, so timing for the other channels is unchanged.
  - It releases in RUN once unmasked.
- NUM_CH=1: RELEASE is entered and left on the same edge (direct HOLD->RUN). done rises together with ch0 release.
- Soft reset:
  - In RUN, soft_req=1 at an edge causes, on that edge: soft_ack=1 (one cycle), ch_rst_out=all ones, done=0, busy=1, state=HOLD, cnt=0. The sequence then repeats exactly as after rst, counting from the edge after the ack.
  - In HOLD/RELEASE, soft_req is not acknowledged and has no effect. It stays pending and is accepted on the first RUN edge, i.e. the edge after done rises.
  - soft_ack is never high in two consecutive cycles. A requester that keeps soft_req high after the ack produces a second accept only after the next sequence completes.
- Simultaneous rst=0 and soft_req=1: rst wins and soft_ack stays 0.
- Counter: cnt wraps never; it is cleared on every state change.

Decomposition:
- Shared package holds the state encoding constants S_HOLD, S_RELEASE, S_RUN (2-bit) and the default timing constants, so Top and benches agree on release times.
- One natural sub-module: rst_seq_counter. It is a CNT_W-bit load/clear/terminal-count counter, reused for the hold and gap phases.

Test Plan:
1. Defaults, rst=0 for 5 cycles then 1 -> ch_rst_out=4'hF through cycle 19. Then ch0 low at cycle 20, ch1 at 24, ch2 at 28, ch3 at 32; done=1 and busy=0 at 32.
2. rst pulled to 0 at cycle 26 (ch0 and ch1 already released) -> next cycle ch_rst_out=4'hF, done=0. Sequence restarts with ch0 low 20 cycles after rst returns to 1.
3. In RUN, soft_req=1 held for 3 cycles -> soft_ack pulses once on the first edge, ch_rst_out=4'hF at that edge, ch0 releases 20 cycles later. No second ack until done.
4. soft_req=1 raised at cycle 10 (HOLD) and held -> no ack until cycle 32. Ack on the edge after done rises, then a new sequence runs.
5. hold_mask=4'b0100 from reset -> ch0, ch1, ch3 release at 20, 24, 32 and ch2 stays 1. done=1 at 32. Clear the mask in RUN -> ch2 drops next cycle. Set it again -> ch2 returns to 1 next cycle.
6. NUM_CH=1, HOLD_CYCLES=3, STAGE_GAP=1 -> ch0 and done change on the same edge at cycle 3. rst=0 together with soft_req=1 -> soft_ack stays 0.
